// File: rtl/tone_freq_meter_pkg.sv
// Shared counter widths and measurement state encoding for the audio meter blocks.
// Latency: none (definitions only); backpressure: not applicable.
package audio_meter_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_ARMED,
    MS_TRACK
  } meas_state_t;

endpackage

// File: rtl/tone_freq_meter_if.sv
// Control inputs and measurement results of the tone frequency meter.
// Latency: none (wires only); backpressure: none, results are level/pulse outputs.
interface tone_freq_meter_if;
  import audio_meter_pkg::*;

  logic             enable;
  logic             audio_in;
  logic [CNT_W-1:0] freq_hz;
  logic             freq_valid;
  logic [CNT_W-1:0] period_cycles;
  logic [CNT_W-1:0] high_cycles;
  logic             silent;

  modport master (
    output enable, audio_in,
    input  freq_hz, freq_valid, period_cycles, high_cycles, silent
  );

  modport slave (
    input  enable, audio_in,
    output freq_hz, freq_valid, period_cycles, high_cycles, silent
  );

endinterface

// File: rtl/tone_freq_meter_edge_sync.sv
// Two-flop synchronizer plus edge register producing single-cycle rise/fall strobes.
// Latency: 3 clk edges from pin to strobe; backpressure: none.
module async_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  // q is the delayed level so it lines up with the strobes
  assign q    = s3_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/tone_freq_meter.sv
// Tone meter: edges per gate window, last period and its high time, silence flag.
// Latency: 4 clk from pin edge to period update; backpressure: none, results registered.
module tone_freq_meter
  import audio_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned GATE_CYCLES    = CLK_HZ,
  parameter int unsigned SILENCE_CYCLES = 2_000_000,
  parameter int unsigned CNT_BITS       = CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  tone_freq_meter_if.slave bus
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef logic [CNT_BITS-1:0] cnt_t;
  localparam cnt_t SAT = '1;

  function automatic cnt_t sat_inc(input cnt_t v, input logic inc);
    return (inc && (v != SAT)) ? cnt_t'(v + 1'b1) : v;
  endfunction

  logic sync_lvl, sync_rise, sync_fall_unused;

  async_edge_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.audio_in),
    .q    (sync_lvl),
    .rise (sync_rise),
    .fall (sync_fall_unused)
  );

  meas_state_t state_q, state_d;
  logic [GW-1:0] gate_cnt_q, gate_cnt_d;
  cnt_t edge_cnt_q, edge_cnt_d;
  cnt_t per_cnt_q, per_cnt_d;
  cnt_t high_cnt_q, high_cnt_d;
  cnt_t freq_q, freq_d;
  cnt_t period_q, period_d;
  cnt_t high_q, high_d;
  logic freq_vld_q, freq_vld_d;
  logic silent_q, silent_d;
  logic silence_hit;

  // Widened so a silence limit beyond the counter range simply never fires
  assign silence_hit = 64'(per_cnt_q) >= 64'(SILENCE_CYCLES);

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    freq_d     = freq_q;
    freq_vld_d = 1'b0;
    period_d   = period_q;
    high_d     = high_q;
    silent_d   = silent_q;

    if (!bus.enable) begin
      state_d    = MS_IDLE;
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      per_cnt_d  = '0;
      high_cnt_d = '0;
      freq_d     = '0;
      period_d   = '0;
      high_d     = '0;
      silent_d   = 1'b1;
    end else begin
      if (gate_cnt_q == GATE_LAST) begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        freq_d     = sat_inc(edge_cnt_q, sync_rise);
        freq_vld_d = 1'b1;
      end else begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = sat_inc(edge_cnt_q, sync_rise);
      end

      per_cnt_d  = silence_hit ? per_cnt_q : sat_inc(per_cnt_q, 1'b1);
      high_cnt_d = sat_inc(high_cnt_q, sync_lvl);

      // The rise cycle itself is high, so the new high count starts at one
      if (sync_rise) begin
        per_cnt_d  = '0;
        high_cnt_d = cnt_t'(1);
        if (state_q == MS_IDLE) begin
          state_d = MS_ARMED;
        end else begin
          state_d  = MS_TRACK;
          period_d = sat_inc(per_cnt_q, 1'b1);
          high_d   = high_cnt_q;
          silent_d = 1'b0;
        end
      end else if (silence_hit) begin
        state_d  = MS_IDLE;
        period_d = '0;
        high_d   = '0;
        silent_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MS_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
      freq_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      freq_vld_q <= 1'b0;
      silent_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
      freq_q     <= freq_d;
      period_q   <= period_d;
      high_q     <= high_d;
      freq_vld_q <= freq_vld_d;
      silent_q   <= silent_d;
    end
  end

  assign bus.freq_hz       = CNT_W'(freq_q);
  assign bus.freq_valid    = freq_vld_q;
  assign bus.period_cycles = CNT_W'(period_q);
  assign bus.high_cycles   = CNT_W'(high_q);
  assign bus.silent        = silent_q;

endmodule

// File: tb/tb_tone_freq_meter.sv
// Bench for tone_freq_meter: full-width instance plus an 8-bit counter build for saturation.
module tb_tone_freq_meter;
  import audio_meter_pkg::*;

  localparam int GATE   = 1000;
  localparam int SIL    = 500;
  localparam int SATW   = 8;
  localparam int SATMAX = 255;

  typedef struct { int p; int h; int f; int per; int hi; } vec_t;
  typedef struct { int r; int f; } pulse_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic audio  = 1'b0;

  int cyc        = 0;
  int n_chk      = 0;
  int n_fail     = 0;
  int gate_start = 0;
  bit gate_live  = 1'b0;
  bit chk_model  = 1'b0;
  pulse_t pq[$];
  vec_t vecs[6];

  tone_freq_meter_if m_if ();
  tone_freq_meter_if s_if ();

  assign m_if.enable   = enable;
  assign m_if.audio_in = audio;
  assign s_if.enable   = enable;
  assign s_if.audio_in = audio;

  tone_freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(GATE), .SILENCE_CYCLES(SIL))
    u_dut (.clk(clk), .reset(rst_n), .bus(m_if));

  tone_freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(GATE), .SILENCE_CYCLES(SIL),
                    .CNT_BITS(SATW))
    u_sat (.clk(clk), .reset(rst_n), .bus(s_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat8(input int v);
    return (v > SATMAX) ? SATMAX : v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pin-level record of every pulse: rise time and fall time in clk edges
  task automatic set_audio(input logic v);
    if (v && !audio) pq.push_back('{cyc, -1});
    else if (!v && audio && pq.size() > 0) pq[pq.size()-1].f = cyc;
    audio = v;
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 100000 && cyc < t; i++) step();
  endtask

  task automatic do_reset();
    step();
    rst_n     = 1'b0;
    gate_live = 1'b0;
    set_audio(1'b0);
    pq.delete();
    repeat (3) step();
    check("rst_freq", m_if.freq_hz, 0);
    check("rst_valid", m_if.freq_valid, 0);
    check("rst_period", m_if.period_cycles, 0);
    check("rst_high", m_if.high_cycles, 0);
    check("rst_silent", m_if.silent, 1);
    check("rst_sat_silent", s_if.silent, 1);
    rst_n      = 1'b1;
    gate_start = cyc;
    gate_live  = enable;
  endtask

  task automatic run_wave(input int p, input int h, input int nval, output int got);
    int t0;
    t0  = cyc;
    got = 0;
    for (int i = 0; i < (nval + 1) * GATE && got < nval; i++) begin
      set_audio(((cyc - t0) % p) < h);
      step();
      if (m_if.freq_valid) got++;
    end
  endtask

  task automatic run_tone(input int p, input int h, input int ncyc);
    int t0;
    t0 = cyc;
    repeat (ncyc) begin
      set_audio(((cyc - t0) % p) < h);
      step();
    end
  endtask

  // Reference: a window closing at edge E holds pin rises in [E-1003, E-4];
  // the reported period is the spacing of the last two rises seen by E.
  task automatic model_check();
    int e, cnt, k, ep, eh;
    e = cyc; cnt = 0; k = -1;
    foreach (pq[i]) begin
      if (pq[i].r >= e - 1003 && pq[i].r <= e - 4) cnt++;
      if (pq[i].r + 4 <= e) k = i;
    end
    check("mdl_freq", m_if.freq_hz, cnt);
    check("mdl_sat_freq", s_if.freq_hz, sat8(cnt));
    if (k >= 1) begin
      ep = pq[k].r - pq[k-1].r;
      eh = pq[k-1].f - pq[k-1].r;
      check("mdl_period", m_if.period_cycles, ep);
      check("mdl_high", m_if.high_cycles, eh);
      check("mdl_silent", m_if.silent, 0);
      check("mdl_sat_period", s_if.period_cycles, sat8(ep));
      check("mdl_sat_high", s_if.high_cycles, sat8(eh));
    end
  endtask

  always @(negedge clk) begin
    bit exp_v;
    exp_v = gate_live && (cyc > gate_start) && (((cyc - gate_start) % GATE) == 0);
    check("freq_valid", m_if.freq_valid, exp_v);
    check("sat_freq_valid", s_if.freq_valid, exp_v);
    if (chk_model && exp_v) model_check();
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int got, n, e, p, h;

    vecs[0] = '{100, 50, 10, 100, 50};
    vecs[1] = '{40, 10, 25, 40, 10};
    vecs[2] = '{200, 1, 5, 200, 1};
    vecs[3] = '{8, 7, 125, 8, 7};
    vecs[4] = '{250, 125, 4, 250, 125};
    vecs[5] = '{4, 2, 250, 4, 2};

    enable = 1'b1;
    do_reset();

    foreach (vecs[i]) begin
      v = vecs[i];
      do_reset();
      run_wave(v.p, v.h, 2, got);
      check("tbl_valid_count", got, 2);
      check("tbl_freq", m_if.freq_hz, v.f);
      check("tbl_period", m_if.period_cycles, v.per);
      check("tbl_high", m_if.high_cycles, v.hi);
      check("tbl_silent", m_if.silent, 0);
      check("tbl_sat_freq", s_if.freq_hz, sat8(v.f));
      check("tbl_sat_period", s_if.period_cycles, sat8(v.per));
    end

    // Dense tone: edge counter of the 8-bit build pins at its maximum
    do_reset();
    chk_model = 1'b1;
    run_wave(3, 1, 2, got);
    chk_model = 1'b0;
    check("sat_valid_count", got, 2);
    check("sat_edge_cnt", s_if.freq_hz, SATMAX);

    // Random per-period tone against the pin-level reference
    do_reset();
    chk_model = 1'b1;
    n = cyc + 5200;
    while (cyc < n) begin
      p = $urandom_range(300, 4);
      h = $urandom_range(p - 1, 1);
      for (int j = 0; j < p; j++) begin
        set_audio(j < h);
        step();
      end
    end
    set_audio(1'b0);
    chk_model = 1'b0;

    // Rise landing on the terminal gate cycle
    do_reset();
    e = cyc;
    wait_until(e + 500);  set_audio(1'b1);
    wait_until(e + 520);  set_audio(1'b0);
    wait_until(e + 996);  set_audio(1'b1);
    wait_until(e + 1000);
    check("term_valid", m_if.freq_valid, 1);
    check("term_freq", m_if.freq_hz, 2);
    check("term_period", m_if.period_cycles, 496);
    check("term_high", m_if.high_cycles, 20);
    check("term_sat_period", s_if.period_cycles, SATMAX);
    check("term_sat_high", s_if.high_cycles, 20);
    wait_until(e + 1010); set_audio(1'b0);
    wait_until(e + 2000);
    check("term_next_valid", m_if.freq_valid, 1);
    check("term_next_freq", m_if.freq_hz, 0);

    // Tone stops: silence after the limit, then an empty window
    do_reset();
    run_tone(100, 50, 2000);
    set_audio(1'b0);
    n = pq[pq.size()-1].r;
    wait_until(n + 494);
    check("stop_before_silent", m_if.silent, 0);
    check("stop_before_period", m_if.period_cycles, 100);
    check("stop_before_high", m_if.high_cycles, 50);
    wait_until(n + 514);
    check("stop_silent", m_if.silent, 1);
    check("stop_period", m_if.period_cycles, 0);
    check("stop_high", m_if.high_cycles, 0);
    e = gate_start + GATE;
    while (e <= n + 1003) e += GATE;
    wait_until(e);
    check("stop_valid", m_if.freq_valid, 1);
    check("stop_freq", m_if.freq_hz, 0);
    check("stop_sat_freq", s_if.freq_hz, 0);

    // Reset mid-window, then enable low mid-window
    do_reset();
    chk_model = 1'b1;
    run_tone(100, 50, 1500);
    do_reset();
    run_tone(100, 50, 2100);
    step();
    enable    = 1'b0;
    gate_live = 1'b0;
    repeat (3) step();
    check("dis_freq", m_if.freq_hz, 0);
    check("dis_period", m_if.period_cycles, 0);
    check("dis_high", m_if.high_cycles, 0);
    check("dis_silent", m_if.silent, 1);
    check("dis_sat_freq", s_if.freq_hz, 0);
    step();
    enable     = 1'b1;
    gate_start = cyc;
    gate_live  = 1'b1;
    run_tone(100, 50, 2100);
    chk_model = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_freq_meter.md
# tone_freq_meter

Measures an incoming single-bit audio tone (PWM square wave from the Pmod audio path) and reports its frequency, period and high time. It is the receiving end of the tone-generation path. Typical use is a loopback from the JB/JC audio outputs for self-test, with results shown on the display logic. The block runs in the `clk` domain and treats `audio_in` as fully asynchronous.

## Interface
- `CLK_HZ`, 100_000_000 — system clock frequency; documentation only, no logic depends on it.
- `GATE_CYCLES`, 100_000_000 — gate window length in `clk` cycles. The default makes `freq_hz` read directly in Hz.
- `SILENCE_CYCLES`, 2_000_000 — period length (20 ms at 100 MHz) beyond which the input is declared silent.
- `clk` input 1 — system clock, rising edge.
- `reset` input 1 — asynchronous, active-low reset.
- `enable` input 1 — measurement enable (mirrors the amplifier-enable/unmute condition).
- `audio_in` input 1 — asynchronous tone input.
- `freq_hz` output 32 — rising edges counted in the last complete gate window.
- `freq_valid` output 1 — one-cycle pulse when `freq_hz` updates.
- `period_cycles` output 32 — `clk` cycles between the last two rising edges.
- `high_cycles` output 32 — high time of that same period, in cycles.
- `silent` output 1 — no rising edge within `SILENCE_CYCLES`, or `enable` low.

## Operation
- **Synchronizer:** 2-FF synchronizer, then an edge register. `rise`/`fall` are single-cycle strobes.
- **Gate counter:** counts 0..`GATE_CYCLES`-1 while `enable`=1.
  - Edge counter increments on `rise`.
  - On the terminal count: `freq_hz` ← edge count, including any `rise` in that same cycle. `freq_valid`=1 for that cycle. Edge counter restarts at 0, and the gate counter restarts with no idle cycle.
- **Period counter:**
  - Increments every cycle and saturates at 2^32-1.
  - High counter increments while the synchronized input is 1, and saturates.
  - On `rise`: `period_cycles` ← period count + 1 and `high_cycles` ← high count. Both counters then restart. The first `rise` after reset or silence only restarts the counters and does not update the outputs.
- **Silence:**
  - Condition: period count reaches `SILENCE_CYCLES`.
  - Effect: `silent`=1 and `period_cycles`=`high_cycles`=0. The period counter holds.
  - `silent` clears on the second `rise`, i.e. the first complete period.
- **Edge counter:** saturates at 2^32-1 and never wraps.
- **`enable` low:**
  - All counters are held at 0, `silent`=1 and `freq_valid`=0.
  - `freq_hz`, `period_cycles` and `high_cycles` are cleared.
  - On `enable` rising, a full new gate starts at count 0.
- **Constant input:** a constant-high or constant-low input produces no `rise`. It ends in silence and `freq_hz`=0 at the next gate.

## Timing
- **Reset state:** every output is 0 except `silent`=1. All counters and synchronizer flops are 0. Reset asserted mid-window discards the partial window and produces no `freq_valid`.
- **Edge latency:** an `audio_in` transition produces `rise`/`fall` 3 `clk` edges later (2 sync + 1 edge register).
- **Period update:** `period_cycles`/`high_cycles` update on the edge after `rise`, a total of 4 cycles from the pin transition.
- **Gate timing:** `freq_valid` pulses exactly every `GATE_CYCLES` cycles while enabled. The first pulse comes `GATE_CYCLES` cycles after reset release or `enable` rise.
- **Glitches:** pulses shorter than one `clk` period may be missed. There is no glitch filtering.

## Structure
- **Shared package `audio_meter_pkg`:** `CNT_W`=32 and the saturating-max constant. The display logic uses the same widths.
- **Sub-module `async_edge_sync`:** 2-FF synchronizer plus rise/fall detector, with ports `clk`, `reset`, `d`, `q`, `rise`, `fall`. It is reused for the button paths.
- **Top level:** gate FSM and period/high measurement in one always-block group. Outputs are registered.

## Test plan
All scenarios use `GATE_CYCLES`=1000 and `SILENCE_CYCLES`=500.
- **Square wave:** period 100, 50 high, `enable`=1 → each `freq_valid` gives `freq_hz`=10. From the second period on, `period_cycles`=100 and `high_cycles`=50. `silent`=0.
- **Narrow duty:** period 40, 10 high → `freq_hz`=25, `period_cycles`=40, `high_cycles`=10.
- **Stop input:** input held low after a tone → 500 cycles after the last `rise`, `silent`=1 and `period_cycles`=`high_cycles`=0. The next gate gives `freq_hz`=0.
- **Terminal-cycle edge:** `rise` landing exactly in gate cycle 999 → counted in the closing window. The next window starts at 0 and does not double-count it.
- **Reset and disable:** `reset` low for 3 cycles mid-window → all outputs 0, `silent`=1, no `freq_valid` until 1000 cycles after release. The same holds for `enable` low.
- **Saturation:** `period_cycles` path forced past 2^32-1 via a small-width build, or high counter held → counters saturate and never wrap to a small value.
